out_bsd_accum: RTL
==================

Name: out_bsd_accum

Overview:
- Bitstream-to-binary decoder; the receive end of the rate-coded bitstream interface.
- Takes DIM_OUT parallel unipolar bitstreams (one bit per lane per cycle) from the FC layer output stage.
- Counts ones per lane over a fixed window of 2^WIN_LOG2 enabled cycles, then presents the binary counts with a one-cycle valid pulse.
- Inverse of the input rate encoder: a binary value v encoded over 2^WIN_LOG2 cycles decodes back to v.

Parameters:
- DIM_OUT, 16, number of parallel bitstream lanes.
- WIN_LOG2, 8, log2 of the decode window length; window = 256 enabled cycles.
- OUTWD, 8, width of each decoded value; must equal WIN_LOG2 (elaboration-time check, fatal on mismatch).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  counting qualifier; a cycle is counted only when high.
- clr  input  1  synchronous window restart; has priority over enable.
- bit_in  input  DIM_OUT  one stream bit per lane, sampled when enable=1.
- out_data  output  DIM_OUT*OUTWD  decoded values, lane i at bits [i*OUTWD +: OUTWD].
- out_valid  output  1  one-cycle pulse; out_data updated in the same cycle.
- busy  output  1  high while a window is partially accumulated (win_cnt != 0).

Behaviour:
- State: win_cnt (WIN_LOG2 bits); per-lane acc (WIN_LOG2+1 bits); out_data register; out_valid register.
- Reset (rst_n=0, async): win_cnt=0, all acc=0, out_data=0, out_valid=0, busy=0.
- clr=1 (any enable): win_cnt<=0, acc<=0, out_valid<=0; out_data holds its last value. A partial window is discarded and no valid is emitted.
- enable=0, clr=0: all state holds; out_valid<=0.
- enable=1, clr=0, win_cnt < 2^WIN_LOG2-1: acc[i]<=acc[i]+bit_in[i]; win_cnt<=win_cnt+1; out_valid<=0.
- enable=1, clr=0, win_cnt == 2^WIN_LOG2-1 (final cycle):
  - total[i] = acc[i]+bit_in[i] (the final bit is included).
  - out_data[i] <= min(total[i], 2^OUTWD-1); saturation applies only when all 256 bits are 1.
  - out_valid<=1 for exactly one cycle.
  - acc<=0; win_cnt wraps to 0.
- Latency: out_valid rises on the clock edge after the 256th enabled cycle of the window.
- Back-to-back windows: the first cycle of the next window may be enabled in the cycle where out_valid=1; no dead cycle.
- busy = (win_cnt != 0), combinational from the register.
- Enable gaps inside a window only stretch it; the result is unaffected.
- Reset mid-window: all state cleared immediately; the partial window is lost.

Optional Feature:
- Macro: BSD_BIPOLAR_EN.
- Defined: out_data lanes are two's-complement values.
  - out_data[i] = sat(total[i] - 2^(WIN_LOG2-1)), clamped to [-2^(OUTWD-1), 2^(OUTWD-1)-1].
  - Range is -128..127 for the defaults; count 256 clamps to 127.
  - Reset value of out_data is 0.
  - Timing, valid and clr behaviour are unchanged.
- Undefined: unipolar unsigned decode as specified above.

Test Plan:
- Reset then enable=1 for 256 cycles: lane0 bit_in=1 every cycle, lane1=0, lane2 alternating 1/0 starting with 1 -> one out_valid pulse on the edge after cycle 256; lane0=255 (saturated), lane1=0, lane2=128; busy=0 afterwards.
- Encoder loopback: input rate encoder driven with value 0x5A on lane 3 for a 256-cycle window -> lane 3 out_data=90 (0x5A); repeat for 0x00, 0x01, 0xFF -> 0, 1, 255.
- enable toggled 1/0 every cycle with lane0=1 -> out_valid after 511 cycles, lane0=255; no pulse earlier.
- clr asserted at win_cnt=100 with enable=1 -> no out_valid; out_data keeps its previous value; next window with lane0 bits summing to 37 -> lane0=37.
- rst_n dropped asynchronously mid-window (win_cnt=200) -> out_data=0, out_valid=0, busy=0 without waiting for a clock edge; recovers on the next full window.
- BSD_BIPOLAR_EN defined: counts 0, 128, 200, 256 -> out_data -128, 0, 72, 127.

Source files
------------

// File: rtl/out_bsd_accum.sv
// out_bsd_accum: bitstream-to-binary decoder for the rate-coded interface.
// Counts the ones on each of DIM_OUT unipolar lanes over a window of
// 2^WIN_LOG2 enabled cycles. At the end of the window it presents the counts
// on out_data together with a one-cycle out_valid pulse.
//
// Optional feature, selected by the macro BSD_BIPOLAR_EN:
//   undefined : unsigned lanes, count clamped to 2^OUTWD-1 (256 -> 255)
//   defined   : two's-complement lanes, count - 2^(WIN_LOG2-1), clamped to
//               [-2^(OUTWD-1), 2^(OUTWD-1)-1] (0 -> -128, 256 -> 127)
//
// Output handshake: out_valid is a push-only pulse with no ready. out_data
// changes only in the cycle out_valid is high and holds until the next
// pulse, so a consumer may read out_data at any time after a pulse. clr and
// enable=0 never change out_data; only a completed window or rst_n does.
module out_bsd_accum #(
  parameter int DIM_OUT  = 16,
  parameter int WIN_LOG2 = 8,
  parameter int OUTWD    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clr,
  input  logic [DIM_OUT-1:0]       bit_in,
  output logic [DIM_OUT*OUTWD-1:0] out_data,
  output logic                     out_valid,
  output logic                     busy
);

  // A window of 2^WIN_LOG2 bits yields counts 0..2^WIN_LOG2, which only fit
  // the clamping below when the output width matches the window exponent.
  if (OUTWD != WIN_LOG2) begin : g_bad_cfg
    $fatal(1, "out_bsd_accum: OUTWD must equal WIN_LOG2");
  end

  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
  localparam logic [WIN_LOG2-1:0] WIN_ONE  = {{(WIN_LOG2-1){1'b0}}, 1'b1};
`ifdef BSD_BIPOLAR_EN
  localparam logic [OUTWD-1:0]    SIGN_BIT = {1'b1, {(OUTWD-1){1'b0}}};
  localparam logic [OUTWD-1:0]    MAX_POS  = {1'b0, {(OUTWD-1){1'b1}}};
`else
  localparam logic [OUTWD-1:0]    MAX_U    = '1;
`endif

  logic [WIN_LOG2-1:0] win_cnt;
  logic [WIN_LOG2:0]   acc   [DIM_OUT];
  logic [WIN_LOG2:0]   total [DIM_OUT];
  logic [DIM_OUT*OUTWD-1:0] dec;
  logic                last_cycle;

  assign busy       = (win_cnt != '0);
  assign last_cycle = (win_cnt == WIN_LAST);

  // Per-lane running total including this cycle's bit, and its decoded form
  // (only latched on the final cycle of a window).
  always_comb begin
    dec = '0;
    for (int i = 0; i < DIM_OUT; i++) begin
      total[i] = acc[i] + {{WIN_LOG2{1'b0}}, bit_in[i]};
`ifdef BSD_BIPOLAR_EN
      // For counts below 2^WIN_LOG2, subtracting the midpoint is a flip of
      // the top bit; the single overflow case (all ones) clamps to +max.
      dec[i*OUTWD +: OUTWD] = total[i][WIN_LOG2] ? MAX_POS
                                                 : (total[i][OUTWD-1:0] ^ SIGN_BIT);
`else
      // Only a full window of ones reaches 2^WIN_LOG2; clamp it to all ones.
      dec[i*OUTWD +: OUTWD] = total[i][WIN_LOG2] ? MAX_U : total[i][OUTWD-1:0];
`endif
    end
  end

  // Window counter, accumulators and registered outputs. clr outranks
  // enable and discards a partial window without touching out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DIM_OUT; i++) acc[i] <= '0;
    end else if (clr) begin
      win_cnt   <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DIM_OUT; i++) acc[i] <= '0;
    end else if (enable) begin
      // Wraps to zero after the final cycle, so the next window may start
      // in the same cycle the pulse is visible.
      win_cnt <= win_cnt + WIN_ONE;
      if (last_cycle) begin
        out_data  <= dec;
        out_valid <= 1'b1;
        for (int i = 0; i < DIM_OUT; i++) acc[i] <= '0;
      end else begin
        out_valid <= 1'b0;
        for (int i = 0; i < DIM_OUT; i++) acc[i] <= total[i];
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
